// File: rtl/led_allocator_pkg.sv
// Shared types and width helpers for the LED allocator and the amplitude preprocessor.
package cchw_led_pkg;

   localparam int DEF_W       = 6;
   localparam int DEF_D       = 10;
   localparam int DEF_BIN_QTY = 12;
   localparam int DEF_LED_QTY = 50;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DIV,
      NEXT,
      REM,
      DONE
   } state_e;

   function automatic int cw_f(input int led_qty);
      return $clog2(led_qty + 1);
   endfunction

   function automatic int sum_w_f(input int w, input int d, input int bin_qty);
      return w + d + $clog2(bin_qty);
   endfunction

   function automatic int num_w_f(input int w, input int d, input int led_qty);
      return w + d + cw_f(led_qty);
   endfunction

endpackage

// File: rtl/led_allocator_if.sv
// Frame bus between the amplitude preprocessor, the LED allocator and the layout stage.
interface led_allocator_if #(
   parameter int W       = cchw_led_pkg::DEF_W,
   parameter int D       = cchw_led_pkg::DEF_D,
   parameter int BIN_QTY = cchw_led_pkg::DEF_BIN_QTY,
   parameter int LED_QTY = cchw_led_pkg::DEF_LED_QTY
);
   localparam int AMP_W = W + D;
   localparam int CW    = cchw_led_pkg::cw_f(LED_QTY);
   localparam int SUM_W = cchw_led_pkg::sum_w_f(W, D, BIN_QTY);
   localparam int TOT_W = CW + $clog2(BIN_QTY);

   logic [BIN_QTY-1:0][AMP_W-1:0] noteAmplitudes_i;
   logic [SUM_W-1:0]              amplitudeSum_i;
   logic                          data_v_i;
   logic [BIN_QTY-1:0][CW-1:0]    ledCounts_o;
   logic [TOT_W-1:0]              ledTotal_o;
   logic                          data_v_o;
   logic                          busy_o;
   logic                          overrun_o;

   modport master (
      output noteAmplitudes_i, amplitudeSum_i, data_v_i,
      input  ledCounts_o, ledTotal_o, data_v_o, busy_o, overrun_o
   );

   modport slave (
      input  noteAmplitudes_i, amplitudeSum_i, data_v_i,
      output ledCounts_o, ledTotal_o, data_v_o, busy_o, overrun_o
   );

endinterface

// File: rtl/led_allocator_divider.sv
// Serial restoring divider: one quotient bit per cycle, MSB first, Q_W cycles after load.
// done is high during the final step; quo is valid from the following cycle.
module serial_divider #(
   parameter int NUM_W = 22,
   parameter int DEN_W = 20,
   parameter int Q_W   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic             busy,
   output logic             done,
   output logic [Q_W-1:0]   quo
);
   localparam int SH_W  = DEN_W + Q_W - 1;
   localparam int R_W   = (SH_W > NUM_W) ? SH_W : NUM_W;
   localparam int CNT_W = $clog2(Q_W + 1);

   logic [R_W-1:0]   rem;
   logic [R_W-1:0]   den_sh;
   logic [CNT_W-1:0] cnt;

   assign busy = (cnt != '0);
   assign done = (cnt == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         rem    <= '0;
         den_sh <= '0;
         cnt    <= '0;
         quo    <= '0;
      end else if (load) begin
         rem    <= R_W'(num);
         den_sh <= R_W'(den) << (Q_W - 1);
         cnt    <= CNT_W'(Q_W);
         quo    <= '0;
      end else if (busy) begin
         if (rem >= den_sh) begin
            rem <= rem - den_sh;
            quo <= {quo[Q_W-2:0], 1'b1};
         end else begin
            quo <= {quo[Q_W-2:0], 1'b0};
         end
         den_sh <= den_sh >> 1;
         cnt    <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/led_allocator.sv
// Splits LED_QTY LEDs across note bins proportionally to amplitude, one shared divider.
// Optional LED_ALLOC_REMAINDER_EN hands the rounding leftover to the loudest bin.
//
// state | meaning
// IDLE  | waiting for a frame; data_v_i captures amplitudes and sum
// LOAD  | build amp[idx]*LED_QTY and start the divider
// DIV   | divider stepping, CW cycles
// NEXT  | store clamped quotient for bin idx, advance or finish
// REM   | add leftover LEDs to the max-amplitude bin (macro builds only)
// DONE  | results presented with data_v_o
module led_allocator
   import cchw_led_pkg::*;
#(
   parameter int W       = DEF_W,
   parameter int D       = DEF_D,
   parameter int BIN_QTY = DEF_BIN_QTY,
   parameter int LED_QTY = DEF_LED_QTY
) (
   input logic             clk,
   input logic             rst,
   led_allocator_if.slave  bus
);
   localparam int AMP_W = W + D;
   localparam int CW    = cw_f(LED_QTY);
   localparam int SUM_W = sum_w_f(W, D, BIN_QTY);
   localparam int NUM_W = num_w_f(W, D, LED_QTY);
   localparam int IDX_W = $clog2(BIN_QTY);
   localparam int TOT_W = CW + IDX_W;
   localparam logic [CW-1:0] LED_MAX = CW'(LED_QTY);

   state_e state, state_nxt;

   logic [IDX_W-1:0]              idx;
   logic [BIN_QTY-1:0][AMP_W-1:0] amp_r;
   logic [SUM_W-1:0]              sum_r;
   logic [BIN_QTY-1:0][CW-1:0]    work, work_d;
   logic [TOT_W-1:0]              total, total_d;
   logic [NUM_W-1:0]              num;
   logic [CW-1:0]                 div_q, q_eff;
   logic                          div_load, div_busy, div_done;
   logic                          last_bin, accept;

`ifdef LED_ALLOC_REMAINDER_EN
   logic [AMP_W-1:0] max_amp;
   logic [IDX_W-1:0] max_idx;
`endif

   assign accept       = (state == IDLE) && bus.data_v_i;
   assign last_bin     = (idx == IDX_W'(BIN_QTY - 1));
   assign num          = NUM_W'(amp_r[idx]) * NUM_W'(LED_QTY);
   assign bus.busy_o   = (state != IDLE);

   serial_divider #(
      .NUM_W (NUM_W),
      .DEN_W (SUM_W),
      .Q_W   (CW)
   ) u_div (
      .clk  (clk),
      .rst  (rst),
      .load (div_load),
      .num  (num),
      .den  (sum_r),
      .busy (div_busy),
      .done (div_done),
      .quo  (div_q)
   );

   // A zero sum still runs the divider so latency is data independent; its result is ignored.
   always_comb begin
      q_eff = div_q;
      if (sum_r == '0)
         q_eff = '0;
      else if (SUM_W'(amp_r[idx]) > sum_r)
         q_eff = LED_MAX;
      else if (div_q > LED_MAX)
         q_eff = LED_MAX;
   end

   always_comb begin
      state_nxt = state;
      div_load  = 1'b0;
      case (state)
         IDLE: if (bus.data_v_i) state_nxt = LOAD;
         LOAD: begin
            div_load  = !div_busy;
            state_nxt = DIV;
         end
         DIV:  if (div_done) state_nxt = NEXT;
         NEXT: begin
            if (!last_bin)
               state_nxt = LOAD;
            else begin
`ifdef LED_ALLOC_REMAINDER_EN
               state_nxt = REM;
`else
               state_nxt = DONE;
`endif
            end
         end
         REM:  state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // work_d is also what the outputs load on entry to DONE, so the last bin needs no extra cycle.
   always_comb begin
      work_d  = work;
      total_d = total;
      if (state == NEXT) begin
         work_d[idx] = q_eff;
         total_d     = total + TOT_W'(q_eff);
      end
`ifdef LED_ALLOC_REMAINDER_EN
      if ((state == REM) && (sum_r != '0) && (total < TOT_W'(LED_QTY))) begin
         work_d[max_idx] = work[max_idx] + CW'(TOT_W'(LED_QTY) - total);
         total_d         = TOT_W'(LED_QTY);
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         idx             <= '0;
         amp_r           <= '0;
         sum_r           <= '0;
         work            <= '0;
         total           <= '0;
         bus.ledCounts_o <= '0;
         bus.ledTotal_o  <= '0;
         bus.data_v_o    <= 1'b0;
         bus.overrun_o   <= 1'b0;
      end else begin
         state        <= state_nxt;
         work         <= work_d;
         total        <= total_d;
         bus.data_v_o <= (state_nxt == DONE);
         if (state_nxt == DONE) begin
            bus.ledCounts_o <= work_d;
            bus.ledTotal_o  <= total_d;
         end
         if (bus.data_v_i && (state != IDLE))
            bus.overrun_o <= 1'b1;
         if (accept) begin
            amp_r <= bus.noteAmplitudes_i;
            sum_r <= bus.amplitudeSum_i;
            idx   <= '0;
            work  <= '0;
            total <= '0;
         end else if ((state == NEXT) && !last_bin) begin
            idx <= idx + 1'b1;
         end
      end
   end

`ifdef LED_ALLOC_REMAINDER_EN
   // Strict compare keeps the lowest index on ties.
   always_ff @(posedge clk) begin
      if (rst) begin
         max_amp <= '0;
         max_idx <= '0;
      end else if (accept) begin
         max_amp <= '0;
         max_idx <= '0;
      end else if ((state == NEXT) && ((idx == '0) || (amp_r[idx] > max_amp))) begin
         max_amp <= amp_r[idx];
         max_idx <= idx;
      end
   end
`endif

endmodule

// File: tb/tb_led_allocator.sv
// Directed bench for led_allocator; expectations follow LED_ALLOC_REMAINDER_EN when defined.
module tb_led_allocator;
   import cchw_led_pkg::*;

`ifdef LED_ALLOC_REMAINDER_EN
   localparam int LAT    = 97;
   localparam bit REM_ON = 1'b1;
`else
   localparam int LAT    = 96;
   localparam bit REM_ON = 1'b0;
`endif

   typedef logic [11:0][15:0] amps_t;
   typedef logic [11:0][5:0]  cnts_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   cap = 0;
   int   n_chk = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   led_allocator_if bus ();

   led_allocator dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic send(input amps_t a, input logic [19:0] s);
      @(negedge clk);
      bus.noteAmplitudes_i = a;
      bus.amplitudeSum_i   = s;
      bus.data_v_i         = 1'b1;
      @(negedge clk);
      bus.data_v_i = 1'b0;
      cap = cyc;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 0; k < 300; k++) begin
         if (bus.data_v_o) begin
            lat = cyc - cap;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_frame(input string tag, input cnts_t e, input logic [9:0] et);
      for (int i = 0; i < 12; i++)
         chk($sformatf("%s_cnt%0d", tag, i), 32'(bus.ledCounts_o[i]), 32'(e[i]));
      chk({tag, "_tot"}, 32'(bus.ledTotal_o), 32'(et));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      amps_t a;
      cnts_t e1, e2, e;
      int    lat;
      int    seen;

      bus.noteAmplitudes_i = '0;
      bus.amplitudeSum_i   = '0;
      bus.data_v_i         = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("rst_dv",   32'(bus.data_v_o), 0);
      chk("rst_busy", 32'(bus.busy_o), 0);
      chk("rst_ovr",  32'(bus.overrun_o), 0);
      chk("rst_tot",  32'(bus.ledTotal_o), 0);
      chk("rst_cnt",  32'(|bus.ledCounts_o), 0);

      // test 1: two equal bins
      e1 = '0; e1[0] = 6'd25; e1[1] = 6'd25;
      a = '0; a[0] = 16'h0800; a[1] = 16'h0800;
      send(a, 20'h01000);
      chk("t1_busy", 32'(bus.busy_o), 1);
      wait_done(lat);
      chk("t1_lat", lat, LAT);
      check_frame("t1", e1, 10'd50);
      @(negedge clk);
      chk("t1_pulse", 32'(bus.data_v_o), 0);
      repeat (4) @(negedge clk);
      chk("t1_hold", 32'(bus.ledTotal_o), 50);
      chk("t1_idle", 32'(bus.busy_o), 0);

      // test 2: floor leaves one LED over
      e2 = '0; e2[0] = 6'd16; e2[1] = REM_ON ? 6'd34 : 6'd33;
      a = '0; a[0] = 16'h0400; a[1] = 16'h0800;
      send(a, 20'h00C00);
      wait_done(lat);
      chk("t2_lat", lat, LAT);
      check_frame("t2", e2, REM_ON ? 10'd50 : 10'd49);

      // test 3: all zero
      send('0, 20'h0);
      wait_done(lat);
      chk("t3_lat", lat, LAT);
      check_frame("t3", '0, 10'd0);

      // test 4: overrun, then DONE-cycle drop and next-cycle accept
      a = '0; a[0] = 16'h0800; a[1] = 16'h0800;
      send(a, 20'h01000);
      chk("t4_ovr_pre", 32'(bus.overrun_o), 0);
      while (cyc - cap < 10) @(negedge clk);
      bus.noteAmplitudes_i = '0;
      bus.amplitudeSum_i   = 20'h00001;
      bus.data_v_i = 1'b1;
      @(negedge clk);
      bus.data_v_i = 1'b0;
      chk("t4_ovr_set", 32'(bus.overrun_o), 1);
      wait_done(lat);
      chk("t4a_lat", lat, LAT);
      check_frame("t4a", e1, 10'd50);
      a = '0; a[0] = 16'h0400; a[1] = 16'h0800;
      bus.noteAmplitudes_i = a;
      bus.amplitudeSum_i   = 20'h00C00;
      bus.data_v_i = 1'b1;
      @(negedge clk);
      chk("t4_keep", 32'(bus.ledTotal_o), 50);
      @(negedge clk);
      bus.data_v_i = 1'b0;
      cap = cyc;
      wait_done(lat);
      chk("t4c_lat", lat, LAT);
      check_frame("t4c", e2, REM_ON ? 10'd50 : 10'd49);
      chk("t4_ovr_stk", 32'(bus.overrun_o), 1);

      // test 5: reset mid-frame
      a = '0; a[0] = 16'h0800; a[1] = 16'h0800;
      send(a, 20'h01000);
      while (cyc - cap < 40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_dv",   32'(bus.data_v_o), 0);
      chk("t5_tot",  32'(bus.ledTotal_o), 0);
      chk("t5_cnt",  32'(|bus.ledCounts_o), 0);
      chk("t5_busy", 32'(bus.busy_o), 0);
      chk("t5_ovr",  32'(bus.overrun_o), 0);
      seen = 0;
      repeat (120) begin
         @(negedge clk);
         if (bus.data_v_o) seen++;
      end
      chk("t5_no_dv", seen, 0);

      // test 6: single full bin, then malformed amp > sum
      a = '0; a[5] = 16'h0066;
      send(a, 20'h00066);
      wait_done(lat);
      chk("t6a_lat", lat, LAT);
      e = '0; e[5] = 6'd50;
      check_frame("t6a", e, 10'd50);

      a = '0; a[0] = 16'h0100;
      send(a, 20'h00080);
      wait_done(lat);
      chk("t6b_lat", lat, LAT);
      e = '0; e[0] = 6'd50;
      check_frame("t6b", e, 10'd50);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
